weight_loader_param: RTL and testbench

Parametrised weight loader for fully-connected layers. On `start` it streams `IN_SIZE*OUT_SIZE` weights of `W` bits from an external read-only BRAM port, beginning at a runtime base address, into a flat register bank feeding the layer's MAC array. Generalises the fixed per-layer loaders:

- BRAM read latency is configurable.
- The base address is a port, not a constant.
- It adds an async active-low reset, an abort input, and a sticky `valid` flag.

---
 rtl/weight_loader_param.sv | 151 +++++++++++++++
 tb/tb_weight_loader_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader_param.sv
// rtl/weight_loader_param.sv - streams TOTAL weights from a BRAM read port into a flat register bank
module weight_loader_param #(
    parameter int IN_SIZE    = 1152,
    parameter int OUT_SIZE   = 8,
    parameter int W          = 8,
    parameter int TOTAL      = IN_SIZE * OUT_SIZE,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [W-1:0]          mem_dout,
    output logic [TOTAL*W-1:0]    data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  valid
);

    localparam int PTR_W = $clog2(TOTAL) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PTR_W-1:0]      issue_cnt;
    logic [PTR_W-1:0]      issue_cnt_next;
    logic [PTR_W-1:0]      wr_ptr;
    logic [RD_LAT-1:0]     pipe;
    logic                  mem_en_next;
    logic [ADDR_WIDTH-1:0] mem_addr_next;
    logic                  busy_next;
    logic                  done_next;
    logic                  valid_next;
    logic                  accept;
    logic                  abort_act;
    logic                  capture;
    logic                  last_capture;

    // A load starts only from IDLE and only when abort is not also asserted.
    assign accept       = (state == S_IDLE) && start && !abort;
    assign abort_act    = abort && (state != S_IDLE);
    // Read data emerging in the abort cycle is treated as in flight and dropped.
    assign capture      = pipe[RD_LAT-1] && !abort_act;
    assign last_capture = capture && (wr_ptr == PTR_W'(TOTAL - 1));

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_cnt_next;
            mem_en    <= mem_en_next;
            mem_addr  <= mem_addr_next;
            busy      <= busy_next;
            done      <= done_next;
            valid     <= valid_next;
        end
    end

    // Next-state and next-output decode; done is a single-cycle pulse.
    always_comb begin
        state_next     = state;
        issue_cnt_next = issue_cnt;
        mem_en_next    = mem_en;
        mem_addr_next  = mem_addr;
        busy_next      = busy;
        done_next      = 1'b0;
        valid_next     = valid;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next     = S_ISSUE;
                    mem_addr_next  = base_addr;
                    mem_en_next    = 1'b1;
                    busy_next      = 1'b1;
                    valid_next     = 1'b0;
                    issue_cnt_next = PTR_W'(1);
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_next  = S_IDLE;
                    mem_en_next = 1'b0;
                    busy_next   = 1'b0;
                end else if (issue_cnt < PTR_W'(TOTAL)) begin
                    // Address wraps naturally at 2^ADDR_WIDTH.
                    mem_addr_next  = mem_addr + ADDR_WIDTH'(1);
                    issue_cnt_next = issue_cnt + PTR_W'(1);
                end else begin
                    state_next  = S_DRAIN;
                    mem_en_next = 1'b0;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end else if (last_capture) begin
                    // Leaving on the final capture lets done land right after it.
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next  = S_IDLE;
                mem_en_next = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    // Read-latency tracker and weight capture into the bank in address order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe     <= '0;
            wr_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (abort_act) begin
                pipe <= '0;
            end else begin
                pipe <= (pipe << 1) | RD_LAT'(mem_en);
            end
            if (accept) begin
                wr_ptr <= '0;
            end else if (capture) begin
                data_out[wr_ptr*W +: W] <= mem_dout;
                wr_ptr                  <= wr_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_weight_loader_param.sv
// tb/tb_weight_loader_param.sv - self-checking bench for weight_loader_param
module tb_weight_loader_param;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a [N];
    logic        abort_a [N];
    logic [17:0] base_a  [N];
    wire         en_a    [N];
    wire         busy_a  [N];
    wire         done_a  [N];
    wire         valid_a [N];
    wire  [17:0] addr_a  [N];
    wire  [63:0] data_a  [N];
    wire  [7:0]  dout_a  [N];
    wire  [3:0]  addr_w;
    logic [7:0]  chain   [N][4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          idx;
        logic [17:0] base;
        logic [17:0] amask;
        int          done_cyc;
        logic [63:0] data;
    } vec_t;

    always #5 clk = ~clk;

    // Instances 0..3: RD_LAT 1..4, 18-bit addresses.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_lat
            weight_loader_param #(
                .IN_SIZE(4), .OUT_SIZE(2), .W(8), .ADDR_WIDTH(18), .RD_LAT(g + 1)
            ) dut (
                .clk(clk), .rst_n(rst_n), .start(start_a[g]), .abort(abort_a[g]),
                .base_addr(base_a[g]), .mem_en(en_a[g]), .mem_addr(addr_a[g]),
                .mem_dout(dout_a[g]), .data_out(data_a[g]), .busy(busy_a[g]),
                .done(done_a[g]), .valid(valid_a[g])
            );
            assign dout_a[g] = chain[g][g];
        end
    endgenerate

    // Instance 4: 4-bit address space for the wrap case.
    weight_loader_param #(
        .IN_SIZE(4), .OUT_SIZE(2), .W(8), .ADDR_WIDTH(4), .RD_LAT(2)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_a[4]), .abort(abort_a[4]),
        .base_addr(base_a[4][3:0]), .mem_en(en_a[4]), .mem_addr(addr_w),
        .mem_dout(dout_a[4]), .data_out(data_a[4]), .busy(busy_a[4]),
        .done(done_a[4]), .valid(valid_a[4])
    );
    assign addr_a[4] = {14'd0, addr_w};
    assign dout_a[4] = chain[4][1];

    // BRAM models: mem[a] = a[7:0], filler 8'hEE on cycles without a read.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            chain[i][0] <= en_a[i] ? addr_a[i][7:0] : 8'hEE;
            for (int j = 1; j < 4; j++) chain[i][j] <= chain[i][j-1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_load(input int idx, input logic [17:0] base, input logic [17:0] amask,
                           input int exp_done, input logic [63:0] exp_data,
                           input int ab_cyc, input int st_cyc);
        bit          aborted;
        int          busy_end;
        int          en_end;
        logic [17:0] ea;
        exp_t        e;
        aborted  = (ab_cyc > 0);
        busy_end = aborted ? ab_cyc : exp_done - 1;
        en_end   = aborted ? ((ab_cyc < 8) ? ab_cyc : 8) : 8;
        @(negedge clk);
        base_a[idx]  = base;
        start_a[idx] = 1'b1;
        if (!aborted) sb.push_back('{exp_done, exp_data});
        for (int c = 1; c <= exp_done + 2; c++) begin
            @(negedge clk);
            chk($sformatf("busy i%0d c%0d", idx, c), 64'(busy_a[idx]), 64'(c <= busy_end));
            chk($sformatf("mem_en i%0d c%0d", idx, c), 64'(en_a[idx]), 64'(c <= en_end));
            if (c <= en_end) begin
                ea = (base + 18'(c - 1)) & amask;
                chk($sformatf("mem_addr i%0d c%0d", idx, c), 64'(addr_a[idx]), 64'(ea));
            end
            chk($sformatf("done i%0d c%0d", idx, c), 64'(done_a[idx]), 64'(!aborted && c == exp_done));
            chk($sformatf("valid i%0d c%0d", idx, c), 64'(valid_a[idx]), 64'(!aborted && c >= exp_done));
            if (done_a[idx]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected done i%0d c%0d", idx, c), 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("done cycle i%0d", idx), 64'(c), 64'(e.cyc));
                    chk($sformatf("data_out i%0d", idx), data_a[idx], e.data);
                end
            end
            start_a[idx] = (c == st_cyc);
            abort_a[idx] = (c == ab_cyc);
        end
        start_a[idx] = 1'b0;
        abort_a[idx] = 1'b0;
        if (sb.size() != 0) begin
            chk($sformatf("missing done i%0d", idx), 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1, 18'd100, 18'h3FFFF, 11, 64'h6B6A696867666564};
        tbl[1] = '{0, 18'd100, 18'h3FFFF, 10, 64'h6B6A696867666564};
        tbl[2] = '{2, 18'd100, 18'h3FFFF, 12, 64'h6B6A696867666564};
        tbl[3] = '{3, 18'd100, 18'h3FFFF, 13, 64'h6B6A696867666564};
        tbl[4] = '{4, 18'd14,  18'h0000F, 11, 64'h0504030201000F0E};
        tbl[5] = '{1, 18'd200, 18'h3FFFF, 11, 64'hCFCECDCCCBCAC9C8};
        for (int i = 0; i < N; i++) begin
            start_a[i] = 1'b0;
            abort_a[i] = 1'b0;
            base_a[i]  = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset mem_en i%0d", i), 64'(en_a[i]), 64'(0));
            chk($sformatf("reset busy i%0d", i), 64'(busy_a[i]), 64'(0));
            chk($sformatf("reset done i%0d", i), 64'(done_a[i]), 64'(0));
            chk($sformatf("reset valid i%0d", i), 64'(valid_a[i]), 64'(0));
            chk($sformatf("reset mem_addr i%0d", i), 64'(addr_a[i]), 64'(0));
            chk($sformatf("reset data_out i%0d", i), data_a[i], 64'(0));
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic loads, latency sweep, address wrap
        for (int t = 0; t < 6; t++)
            do_load(tbl[t].idx, tbl[t].base, tbl[t].amask, tbl[t].done_cyc, tbl[t].data, 0, 0);

        // Ignored start in cycle 3: timing unchanged
        do_load(1, 18'd100, 18'h3FFFF, 11, 64'h6B6A696867666564, 0, 3);

        // Abort in cycle 4, then a fresh load
        do_load(1, 18'd100, 18'h3FFFF, 11, 64'h0, 4, 0);
        do_load(1, 18'd200, 18'h3FFFF, 11, 64'hCFCECDCCCBCAC9C8, 0, 0);

        // start and abort together in IDLE: no load
        @(negedge clk);
        base_a[1]  = 18'd100;
        start_a[1] = 1'b1;
        abort_a[1] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_a[1] = 1'b0;
            abort_a[1] = 1'b0;
            chk($sformatf("collision busy c%0d", c), 64'(busy_a[1]), 64'(0));
            chk($sformatf("collision mem_en c%0d", c), 64'(en_a[1]), 64'(0));
            chk($sformatf("collision done c%0d", c), 64'(done_a[1]), 64'(0));
        end

        // Async reset mid-ISSUE
        @(negedge clk);
        base_a[1]  = 18'd100;
        start_a[1] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start_a[1] = 1'b0;
        end
        chk("pre-reset busy", 64'(busy_a[1]), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async mem_en", 64'(en_a[1]), 64'(0));
        chk("async busy", 64'(busy_a[1]), 64'(0));
        chk("async valid", 64'(valid_a[1]), 64'(0));
        chk("async data_out", data_a[1], 64'(0));
        chk("async mem_addr", 64'(addr_a[1]), 64'(0));
        chk("async valid other", 64'(valid_a[0]), 64'(0));
        chk("async data_out other", data_a[0], 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(1, 18'd200, 18'h3FFFF, 11, 64'hCFCECDCCCBCAC9C8, 0, 0);
        do_load(4, 18'd3,   18'h0000F, 11, 64'h0A09080706050403, 0, 0);

        chk("scoreboard empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
